draw_engine: RTL

DRAW_ENGINE -- requirements
Module: draw_engine

---
 rtl/draw_engine.sv | 134 +++++++++++++
 1 files changed

// File: rtl/draw_engine.sv
// draw_engine: copies a 16x16 sprite or a 160x120 screen from a source memory
// into the frame buffer, with transparency and screen-edge clipping.
`default_nettype none

module draw_engine #(
  parameter int         SPR_W       = 16,
  parameter int         SCR_W       = 160,
  parameter int         SCR_H       = 120,
  parameter logic [2:0] TRANSPARENT = 3'b101
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        copy_enable,
  input  logic        full_screen,
  input  logic [1:0]  memory_select,
  input  logic [3:0]  sprite_id,
  input  logic [7:0]  tile_x,
  input  logic [6:0]  tile_y,
  output logic [1:0]  src_bank,
  output logic [14:0] src_addr,
  input  logic [2:0]  src_data,
  output logic [7:0]  buf_x,
  output logic [6:0]  buf_y,
  output logic [2:0]  buf_colour,
  output logic        buf_we,
  output logic        finished,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t      state;
  state_t      state_next;

  logic        fs;
  logic [1:0]  bank;
  logic [3:0]  id;
  logic [7:0]  tx;
  logic [6:0]  ty;
  logic [7:0]  px;
  logic [6:0]  py;
  logic        pv;
  logic [7:0]  ppx;
  logic [6:0]  ppy;

  logic [7:0]  x_max;
  logic [6:0]  y_max;
  logic        px_end;
  logic        py_end;
  logic [14:0] fs_addr;
  logic [8:0]  wx;
  logic [7:0]  wy;
  logic        visible;

  assign x_max  = fs ? 8'(SCR_W - 1) : 8'(SPR_W - 1);
  assign y_max  = fs ? 7'(SCR_H - 1) : 7'(SPR_W - 1);
  assign px_end = (px == x_max);
  assign py_end = (py == y_max);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (copy_enable) state_next = RUN;
      RUN: begin
        if (!copy_enable)          state_next = IDLE;
        else if (px_end && py_end) state_next = FLUSH;
      end
      FLUSH:   state_next = copy_enable ? DONE : IDLE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fs   <= 1'b0;
      bank <= 2'd0;
      id   <= 4'd0;
      tx   <= 8'd0;
      ty   <= 7'd0;
      px   <= 8'd0;
      py   <= 7'd0;
      pv   <= 1'b0;
      ppx  <= 8'd0;
      ppy  <= 7'd0;
    end else begin
      // pv marks that src_data next cycle belongs to the pixel at (ppx, ppy)
      pv  <= (state == RUN) && copy_enable;
      ppx <= px;
      ppy <= py;
      if (state == IDLE && copy_enable) begin
        fs   <= full_screen;
        bank <= memory_select;
        id   <= sprite_id;
        tx   <= tile_x;
        ty   <= tile_y;
        px   <= 8'd0;
        py   <= 7'd0;
      end else if (state == RUN && copy_enable) begin
        if (px_end) begin
          px <= 8'd0;
          py <= py_end ? 7'd0 : py + 7'd1;
        end else begin
          px <= px + 8'd1;
        end
      end
    end
  end

  // py*160 as shifts: 128 + 32
  assign fs_addr  = ({8'd0, py} << 7) + ({8'd0, py} << 5) + {7'd0, px};
  assign src_addr = (state != RUN) ? 15'd0
                  : fs ? fs_addr : {3'b000, id, py[3:0], px[3:0]};
  assign src_bank = bank;

  assign wx      = fs ? {1'b0, ppx} : {1'b0, tx} + {1'b0, ppx};
  assign wy      = fs ? {1'b0, ppy} : {1'b0, ty} + {1'b0, ppy};
  assign visible = (wx < 9'(SCR_W)) && (wy < 8'(SCR_H));

  assign buf_we     = pv && visible && (fs || src_data != TRANSPARENT);
  assign buf_colour = buf_we ? src_data : 3'd0;
  assign buf_x      = pv ? wx[7:0] : 8'd0;
  assign buf_y      = pv ? wy[6:0] : 7'd0;
  assign finished   = (state == DONE);
  assign busy       = (state != IDLE);

endmodule

`default_nettype wire
